// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding a single 8N1/8N2 UART transmitter.
// All frame timing advances only on the baud_clk_en pulse.
module uart_tx_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int STOP_BITS = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   baud_clk_en,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   tx,
   output logic                   busy,
   output logic [2:0]             grant_id
);

   typedef enum logic [1:0] {IDLE, WAIT_START, DATA, STOP} state_t;

   state_t      state, state_nxt;
   logic [7:0]  shift_q, shift_nxt;
   logic [3:0]  bit_cnt, bit_cnt_nxt;
   logic [1:0]  stop_cnt, stop_cnt_nxt;
   logic        tx_nxt, busy_nxt;
   logic [2:0]  grant_nxt;
   logic [2:0]  ptr, ptr_nxt;
   logic        found;
   logic [2:0]  winner;
   logic [7:0]  win_byte;
   int          arb_dist, arb_best;

   // Lowest distance from the pointer (with wrap) among valid requesters wins.
   always_comb begin
      found    = 1'b0;
      winner   = 3'd0;
      arb_dist = 0;
      arb_best = NUM_REQ;
      win_byte = 8'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         arb_dist = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
         if (req_valid[i] && (arb_dist < arb_best)) begin
            arb_best = arb_dist;
            winner   = 3'(i);
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state == IDLE) && found && (winner == 3'(i));
         if (winner == 3'(i))
            win_byte = req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift_q;
      bit_cnt_nxt  = bit_cnt;
      stop_cnt_nxt = stop_cnt;
      tx_nxt       = tx;
      busy_nxt     = busy;
      grant_nxt    = grant_id;
      ptr_nxt      = ptr;
      case (state)
         IDLE: begin
            // A baud pulse on the accept cycle is deliberately ignored here.
            if (found) begin
               shift_nxt = win_byte;
               grant_nxt = winner;
               ptr_nxt   = (winner == 3'(NUM_REQ-1)) ? 3'd0 : winner + 3'd1;
               busy_nxt  = 1'b1;
               state_nxt = WAIT_START;
            end
         end
         WAIT_START: begin
            if (baud_clk_en) begin
               tx_nxt      = 1'b0;
               bit_cnt_nxt = 4'd0;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            if (baud_clk_en) begin
               if (bit_cnt < 4'd8) begin
                  tx_nxt      = shift_q[0];
                  shift_nxt   = {1'b0, shift_q[7:1]};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else begin
                  tx_nxt       = 1'b1;
                  stop_cnt_nxt = 2'd1;
                  state_nxt    = STOP;
               end
            end
         end
         STOP: begin
            if (baud_clk_en) begin
               if (int'(stop_cnt) < STOP_BITS) begin
                  tx_nxt       = 1'b1;
                  stop_cnt_nxt = stop_cnt + 2'd1;
               end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         shift_q  <= 8'd0;
         bit_cnt  <= 4'd0;
         stop_cnt <= 2'd0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         grant_id <= 3'd0;
         ptr      <= 3'd0;
      end else begin
         state    <= state_nxt;
         shift_q  <= shift_nxt;
         bit_cnt  <= bit_cnt_nxt;
         stop_cnt <= stop_cnt_nxt;
         tx       <= tx_nxt;
         busy     <= busy_nxt;
         grant_id <= grant_nxt;
         ptr      <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: 8N1 instance plus an 8N2 instance.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        baud_clk_en = 1'b0;
   logic [3:0]  req_valid = '0, req_valid2 = '0;
   logic [31:0] req_data = '0, req_data2 = '0;
   logic [3:0]  req_ready, req_ready2;
   logic        tx, tx2, busy, busy2;
   logic [2:0]  grant_id, grant_id2;
   int          tests = 0;
   int          fails = 0;

   uart_tx_scheduler #(.NUM_REQ(4), .STOP_BITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .tx(tx), .busy(busy), .grant_id(grant_id));

   uart_tx_scheduler #(.NUM_REQ(4), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .baud_clk_en(baud_clk_en),
      .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
      .tx(tx2), .busy(busy2), .grant_id(grant_id2));

   always #5 clk = ~clk;

   // Baud pulse high for one posedge in every four.
   initial begin : baud_gen
      int bcnt;
      bcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         bcnt = (bcnt + 1) % 4;
         baud_clk_en = (bcnt == 3);
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge one cycle after the next baud pulse edge.
   task automatic next_pulse(input string tag);
      int n;
      n = 0;
      while (!baud_clk_en) begin
         @(negedge clk);
         n++;
         if (n > 16) begin
            chk({tag, "_pulse_timeout"}, 32'd0, 32'd1);
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_accept(input string tag, output int waited);
      waited = 0;
      #1;
      while (req_ready == 4'd0 && waited < 64) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (req_ready == 4'd0)
         chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, busy, 1'b0);
   endtask

   task automatic run_frame(input string tag, input int exp_gid, input logic [7:0] exp_byte,
                            input logic [3:0] valid_after, output int waited);
      logic [9:0] s;
      wait_accept(tag, waited);
      chk({tag, "_ready"}, req_ready, 32'd1 << exp_gid);
      @(negedge clk);
      chk({tag, "_grant_id"}, grant_id, exp_gid);
      chk({tag, "_busy_on"}, busy, 1'b1);
      chk({tag, "_ready_off"}, req_ready, 4'd0);
      req_valid = valid_after;
      for (int k = 0; k < 10; k++) begin
         next_pulse(tag);
         s[k] = tx;
      end
      chk({tag, "_frame"}, s, {1'b1, exp_byte, 1'b0});
      chk({tag, "_busy_stop"}, busy, 1'b1);
      next_pulse(tag);
      chk({tag, "_busy_off"}, busy, 1'b0);
   endtask

   initial begin : main
      int w;
      int lows, first_low, n;
      logic [10:0] s2;

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant", grant_id, 3'd0);
      chk("rst_ready", req_ready, 4'd0);
      chk("rst_tx2", tx2, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Single byte from requester 2
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      run_frame("single", 2, 8'hA5, 4'b0000, w);

      // Round robin, all valid continuously, back-to-back frames
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_data = 32'h1312_1110;
      req_valid = 4'hF;
      run_frame("rr0", 0, 8'h10, 4'hF, w);
      run_frame("rr1", 1, 8'h11, 4'hF, w);
      chk("rr1_b2b", w, 0);
      run_frame("rr2", 2, 8'h12, 4'hF, w);
      chk("rr2_b2b", w, 0);
      run_frame("rr3", 3, 8'h13, 4'hF, w);
      chk("rr3_b2b", w, 0);
      run_frame("rr4", 0, 8'h10, 4'b1000, w);
      chk("rr4_b2b", w, 0);

      // Pointer wrap: serve 3, then only 1 and 3 valid
      run_frame("wrap_a", 3, 8'h13, 4'b1010, w);
      run_frame("wrap_b", 1, 8'h11, 4'b1010, w);
      run_frame("wrap_c", 3, 8'h13, 4'b0000, w);

      // Two stop bits, byte 0xFF
      req_data2[7:0] = 8'hFF;
      req_valid2 = 4'b0001;
      wait_idle("sb2_pre");
      #1;
      chk("sb2_ready", req_ready2, 4'b0001);
      @(negedge clk);
      req_valid2 = 4'b0000;
      chk("sb2_busy_on", busy2, 1'b1);
      for (int k = 0; k < 11; k++) begin
         next_pulse("sb2");
         s2[k] = tx2;
      end
      chk("sb2_frame", s2, {2'b11, 8'hFF, 1'b0});
      chk("sb2_busy_stop", busy2, 1'b1);
      next_pulse("sb2");
      chk("sb2_busy_off", busy2, 1'b0);

      // Reset during data bit 4
      req_data = 32'h0000_0000;
      req_valid = 4'b0100;
      #1;
      chk("mid_ready", req_ready, 4'b0100);
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (6) next_pulse("mid");
      chk("mid_bit4", tx, 1'b0);
      chk("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_grant", grant_id, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'b1000;
      #1;
      chk("mid_only3", req_ready, 4'b1000);
      req_valid = 4'b1001;
      #1;
      chk("mid_both", req_ready, 4'b0001);
      @(negedge clk);
      chk("mid_grant0", grant_id, 3'd0);
      req_valid = 4'b0000;
      wait_idle("mid");

      // Accept coincident with a baud pulse
      n = 0;
      while (!baud_clk_en && n < 16) begin
         @(negedge clk);
         n++;
      end
      req_data[15:8] = 8'hFF;
      req_valid = 4'b0010;
      #1;
      chk("coin_ready", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      lows = 0;
      first_low = 0;
      for (int i = 1; i <= 16; i++) begin
         if (!tx) begin
            lows++;
            if (first_low == 0) first_low = i;
         end
         @(negedge clk);
      end
      chk("coin_first_low", first_low, 5);
      chk("coin_low_cycles", lows, 4);
      wait_idle("coin");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
